// File: rtl/div_unit_if.sv
// Handshake and result bundle for the iterative divider.
// The master drives operands and start; the slave returns results and status.
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, is_signed, a, b,
    input  quotient, remainder, busy, done, div_by_zero, overflow
  );

  modport slave (
    input  start, is_signed, a, b,
    output quotient, remainder, busy, done, div_by_zero, overflow
  );
endinterface

// File: rtl/div_unit.sv
// Restoring radix-2 divider producing LO (quotient) and HI (remainder).
// Works on operand magnitudes and applies truncating-division signs at the end.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset_n,
  div_unit_if.slave dif
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, (WIDTH-1)'(0)};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               dz_pend_q, dz_pend_d;
  logic               ov_pend_q, ov_pend_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;
  logic               ov_q, ov_d;

  logic [WIDTH-1:0]   a_mag_c;
  logic [WIDTH-1:0]   b_mag_c;
  logic [WIDTH:0]     part_c;
  logic [WIDTH-1:0]   diff_c;
  logic               ge_c;

  // Operand magnitudes and one restoring step; part_c carries the shifted-out bit
  always_comb begin
    a_mag_c = (dif.is_signed && dif.a[WIDTH-1]) ? (~dif.a + WIDTH'(1)) : dif.a;
    b_mag_c = (dif.is_signed && dif.b[WIDTH-1]) ? (~dif.b + WIDTH'(1)) : dif.b;
    part_c  = work_q[2*WIDTH-1:WIDTH-1];
    ge_c    = (part_c >= {1'b0, dvsr_q});
    diff_c  = part_c[WIDTH-1:0] - dvsr_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    dvsr_d    = dvsr_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    dz_pend_d = dz_pend_q;
    ov_pend_d = ov_pend_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    ov_d      = ov_q;

    unique case (state_q)
      S_IDLE: begin
        if (dif.start) begin
          busy_d    = 1'b1;
          dz_d      = 1'b0;
          ov_d      = 1'b0;
          qneg_d    = dif.is_signed & (dif.a[WIDTH-1] ^ dif.b[WIDTH-1]);
          rneg_d    = dif.is_signed & dif.a[WIDTH-1];
          dz_pend_d = (dif.b == '0);
          ov_pend_d = dif.is_signed && (dif.a == MIN_VAL) && (dif.b == '1);
          if (dif.b == '0) begin
            // Raw dividend parked in the low half becomes the remainder
            work_d  = {WIDTH'(0), dif.a};
            state_d = S_FINISH;
          end else begin
            work_d  = {WIDTH'(0), a_mag_c};
            dvsr_d  = b_mag_c;
            cnt_d   = CNT_W'(WIDTH);
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        work_d = {(ge_c ? diff_c : part_c[WIDTH-1:0]), work_q[WIDTH-2:0], ge_c};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        if (dz_pend_q) begin
          quo_d = '1;
          rem_d = work_q[WIDTH-1:0];
        end else begin
          quo_d = qneg_q ? (~work_q[WIDTH-1:0] + WIDTH'(1)) : work_q[WIDTH-1:0];
          rem_d = rneg_q ? (~work_q[2*WIDTH-1:WIDTH] + WIDTH'(1))
                         : work_q[2*WIDTH-1:WIDTH];
        end
        dz_d    = dz_pend_q;
        ov_d    = ov_pend_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      dvsr_q    <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      dz_pend_q <= 1'b0;
      ov_pend_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      dvsr_q    <= dvsr_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      dz_pend_q <= dz_pend_d;
      ov_pend_q <= ov_pend_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      ov_q      <= ov_d;
    end
  end

  assign dif.quotient    = quo_q;
  assign dif.remainder   = rem_q;
  assign dif.busy        = busy_q;
  assign dif.done        = done_q;
  assign dif.div_by_zero = dz_q;
  assign dif.overflow    = ov_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: 32-bit and 8-bit instances, vector table, handshake/reset
// sequences and a random 8-bit run against an integer reference.
module tb_div_unit;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(32)) if32 ();
  div_unit_if #(.WIDTH(8))  if8 ();

  div_unit #(.WIDTH(32)) u_div32 (.clk(clk), .reset_n(reset_n), .dif(if32));
  div_unit #(.WIDTH(8))  u_div8  (.clk(clk), .reset_n(reset_n), .dif(if8));

  typedef struct {
    int          w;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
    int          lat;
  } vec_t;

  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int w, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic st);
    if (w == 32) begin
      if32.start = st; if32.is_signed = s; if32.a = a; if32.b = b;
    end else begin
      if8.start = st; if8.is_signed = s; if8.a = a[7:0]; if8.b = b[7:0];
    end
  endtask

  task automatic sample(input int w, output logic [31:0] q, output logic [31:0] r,
                        output logic [3:0] st);
    if (w == 32) begin
      q = if32.quotient; r = if32.remainder;
      st = {if32.busy, if32.done, if32.div_by_zero, if32.overflow};
    end else begin
      q = {24'b0, if8.quotient}; r = {24'b0, if8.remainder};
      st = {if8.busy, if8.done, if8.div_by_zero, if8.overflow};
    end
  endtask

  // One operation; operands are scrambled after acceptance, optional ignored start pulse
  task automatic op(input vec_t v, input string nm, input int pulse_at);
    logic [31:0] q, r;
    logic [3:0]  st;
    vec_t        e;
    int          lat;
    sb.push_back(v);
    drive(v.w, v.sgn, v.a, v.b, 1'b1);
    @(negedge clk);
    drive(v.w, ~v.sgn, ~v.a, ~v.b, 1'b0);
    sample(v.w, q, r, st);
    check({nm, " accept"}, {28'b0, st}, 32'h8);
    lat = 0;
    while (!st[2] && lat < v.lat + 4) begin
      @(negedge clk);
      lat++;
      if (lat == pulse_at) drive(v.w, v.sgn, 32'd3, 32'd1, 1'b1);
      else                 drive(v.w, ~v.sgn, ~v.a, ~v.b, 1'b0);
      sample(v.w, q, r, st);
    end
    drive(v.w, v.sgn, v.a, v.b, 1'b0);
    e = sb.pop_front();
    check({nm, " done"}, {31'b0, st[2]}, 32'd1);
    check({nm, " latency"}, 32'(lat), 32'(e.lat));
    check({nm, " quotient"}, q, e.q);
    check({nm, " remainder"}, r, e.r);
    check({nm, " flags"}, {30'b0, st[1:0]}, {30'b0, e.dz, e.ov});
    @(negedge clk);
    sample(v.w, q, r, st);
    check({nm, " hold"}, {q[30:0], st[2]}, {e.q[30:0], 1'b0});
  endtask

  initial begin
    vec_t        tbl[12];
    vec_t        v;
    logic [31:0] q, r;
    logic [3:0]  st;
    int          ai, bi;

    tbl[0]  = '{32, 1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 1'b0, 33};
    tbl[1]  = '{32, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 33};
    tbl[2]  = '{32, 1'b0, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 32'hF,        1'b0, 1'b0, 33};
    tbl[3]  = '{32, 1'b1, 32'hFFFFFFFF, 32'h10,       32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 33};
    tbl[4]  = '{32, 1'b0, 32'h1234,     32'h0,        32'hFFFFFFFF, 32'h1234,     1'b1, 1'b0, 1};
    tbl[5]  = '{32, 1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 33};
    tbl[6]  = '{32, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        1'b0, 1'b1, 33};
    tbl[7]  = '{32, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 1'b0, 33};
    tbl[8]  = '{32, 1'b1, 32'h80000000, 32'h0,        32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0, 1};
    tbl[9]  = '{32, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0, 1'b0, 33};
    tbl[10] = '{8,  1'b1, 32'h80,       32'h03,       32'hD6,       32'hFE,       1'b0, 1'b0, 9};
    tbl[11] = '{8,  1'b0, 32'hFF,       32'hFF,       32'h1,        32'h0,        1'b0, 1'b0, 9};

    reset_n = 1'b0;
    drive(32, 1'b0, 32'd0, 32'd0, 1'b0);
    drive(8,  1'b0, 32'd0, 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    sample(32, q, r, st);
    check("reset32", q | r | {28'b0, st}, 32'd0);
    sample(8, q, r, st);
    check("reset8", q | r | {28'b0, st}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) op(tbl[i], $sformatf("vec%0d", i), -1);

    // Start pulse at cycle 10 must be ignored
    v = '{32, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33};
    op(v, "busy_start", 10);

    // Reset in the middle of an operation
    drive(32, 1'b0, 32'd1000, 32'd3, 1'b1);
    @(negedge clk);
    drive(32, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (19) @(negedge clk);
    reset_n = 1'b0;
    #1;
    sample(32, q, r, st);
    check("midrst outputs", q | r | {28'b0, st}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sample(32, q, r, st);
      check("midrst no_done", {28'b0, st}, 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    op(tbl[0], "post_reset", -1);

    // Random 8-bit operations against integer arithmetic
    for (int k = 0; k < 3000; k++) begin
      v.w   = 8;
      v.sgn = 1'($urandom_range(0, 1));
      v.a   = 32'($urandom_range(0, 255));
      v.b   = 32'($urandom_range(0, 255));
      if (k % 50 == 0) begin v.a = 32'h80; v.b = 32'hFF; end
      if ($urandom_range(0, 15) == 0) v.b = 32'd0;
      ai = v.sgn ? int'($signed(v.a[7:0])) : int'(v.a[7:0]);
      bi = v.sgn ? int'($signed(v.b[7:0])) : int'(v.b[7:0]);
      if (bi == 0) begin
        v.q = 32'hFF; v.r = v.a; v.dz = 1'b1; v.ov = 1'b0; v.lat = 1;
      end else begin
        v.q   = {24'b0, 8'(ai / bi)};
        v.r   = {24'b0, 8'(ai % bi)};
        v.dz  = 1'b0;
        v.ov  = v.sgn && (v.a == 32'h80) && (v.b == 32'hFF);
        v.lat = 9;
      end
      op(v, $sformatf("rnd%0d", k), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
